// File: rtl/weapons_engagement_unit_if.sv
// Handshake bundle between combat management and the weapons engagement unit.
// master drives sensor/pilot inputs; slave (the unit) drives launch/status outputs.
interface weapons_engagement_unit_if;
    logic        threat_detected;
    logic [31:0] distance_to_target;
    logic        safe_to_engage;
    logic        emergency_landing_alert;
    logic        fire_authorized;
    logic        reload;
    logic        missile_launch;
    logic        lock_acquired;
    logic [3:0]  missiles_remaining;
    logic [2:0]  WEU_state;

    modport master (
        output threat_detected, distance_to_target, safe_to_engage,
        output emergency_landing_alert, fire_authorized, reload,
        input  missile_launch, lock_acquired, missiles_remaining, WEU_state
    );

    modport slave (
        input  threat_detected, distance_to_target, safe_to_engage,
        input  emergency_landing_alert, fire_authorized, reload,
        output missile_launch, lock_acquired, missiles_remaining, WEU_state
    );
endinterface

// File: rtl/weapons_engagement_unit.sv
// Weapons engagement unit: lock-on, arming, launch, cooldown, emergency safing.
// Ports: CLK, RST (sync active-high), bus (slave modport: threat/range/permission
// inputs, launch pulse, lock flag, inventory and state outputs).
module weapons_engagement_unit #(
    parameter int unsigned LOCK_CYCLES     = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned MISSILE_COUNT   = 4,
    parameter int unsigned MIN_ENGAGE_DIST = 1000
) (
    input  logic                            CLK,
    input  logic                            RST,
    weapons_engagement_unit_if.slave        bus
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOCKING  = 3'd1,
        ARMED    = 3'd2,
        LAUNCH   = 3'd3,
        COOLDOWN = 3'd4,
        SAFED    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]   cd_cnt_q, cd_cnt_d;
    logic [3:0]      inv_q, inv_d;
    logic            qualify;

    assign qualify = bus.threat_detected &&
                     (bus.distance_to_target >= 32'(MIN_ENGAGE_DIST));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            cd_cnt_q   <= '0;
            inv_q      <= 4'(MISSILE_COUNT);
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
            inv_q      <= inv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cd_cnt_d   = cd_cnt_q;
        inv_d      = inv_q;
        unique case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if (bus.reload) inv_d = 4'(MISSILE_COUNT);
                // Transition uses the pre-refill inventory.
                if (qualify && inv_q != 4'd0) begin
                    if (LOCK_CYCLES == 1) begin
                        state_d = ARMED;
                    end else begin
                        state_d    = LOCKING;
                        lock_cnt_d = LW'(1);
                    end
                end
            end
            LOCKING: begin
                if (!qualify) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LW'(LOCK_CYCLES - 1)) begin
                    state_d    = ARMED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            ARMED: begin
                // Range is deliberately not rechecked once armed.
                if (!bus.threat_detected) begin
                    state_d = IDLE;
                end else if (bus.fire_authorized && bus.safe_to_engage) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                inv_d    = inv_q - 4'd1;
                state_d  = COOLDOWN;
                cd_cnt_d = '0;
            end
            COOLDOWN: begin
                if (cd_cnt_q == CW'(COOLDOWN_CYCLES - 1)) begin
                    state_d  = IDLE;
                    cd_cnt_d = '0;
                end else begin
                    cd_cnt_d = cd_cnt_q + CW'(1);
                end
            end
            SAFED: begin
                lock_cnt_d = '0;
                cd_cnt_d   = '0;
                if (bus.reload) inv_d = 4'(MISSILE_COUNT);
                if (!bus.emergency_landing_alert) state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
                cd_cnt_d   = '0;
            end
        endcase
        // Alert overrides the transition; a LAUNCH-cycle decrement still stands.
        if (bus.emergency_landing_alert) begin
            state_d    = SAFED;
            lock_cnt_d = '0;
            cd_cnt_d   = '0;
        end
    end

    assign bus.missile_launch     = (state_q == LAUNCH);
    assign bus.lock_acquired      = (state_q == ARMED);
    assign bus.missiles_remaining = inv_q;
    assign bus.WEU_state          = state_q;
endmodule

// File: tb/tb_weapons_engagement_unit.sv
// Directed scoreboard bench for weapons_engagement_unit (default parameters).
// Expected state/inventory pushed per step, popped and checked after each edge.
module tb_weapons_engagement_unit;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOCK = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_LNCH = 3'd3;
    localparam logic [2:0] S_COOL = 3'd4;
    localparam logic [2:0] S_SAFE = 3'd5;

    logic clk;
    logic rst;
    int   total;
    int   pass_cnt;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [3:0] inv;
    } exp_t;

    exp_t q[$];

    weapons_engagement_unit_if bus ();

    weapons_engagement_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_out();
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".state"}, {1'b0, bus.WEU_state}, {1'b0, e.st});
        chk({e.tag, ".launch"}, {3'b0, bus.missile_launch},
            {3'b0, (e.st == S_LNCH)});
        chk({e.tag, ".lock"}, {3'b0, bus.lock_acquired},
            {3'b0, (e.st == S_ARM)});
        chk({e.tag, ".inv"}, bus.missiles_remaining, e.inv);
    endtask

    task automatic step(input string tag, input logic [2:0] st,
                        input logic [3:0] inv);
        q.push_back('{tag, st, inv});
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Full engagement from IDLE with qualify, fire and safe held.
    task automatic engage(input string tag, input logic [3:0] inv);
        bus.threat_detected    = 1'b1;
        bus.distance_to_target = 32'd5000;
        bus.fire_authorized    = 1'b1;
        bus.safe_to_engage     = 1'b1;
        for (int i = 0; i < 3; i++) step({tag, ".lock"}, S_LOCK, inv);
        step({tag, ".armed"}, S_ARM, inv);
        step({tag, ".launch"}, S_LNCH, inv);
        for (int i = 0; i < 8; i++) step({tag, ".cool"}, S_COOL, inv - 4'd1);
        step({tag, ".idle"}, S_IDLE, inv - 4'd1);
    endtask

    initial begin
        total    = 0;
        pass_cnt = 0;
        rst      = 1'b1;
        bus.threat_detected         = 1'b0;
        bus.distance_to_target      = 32'd0;
        bus.safe_to_engage          = 1'b0;
        bus.emergency_landing_alert = 1'b0;
        bus.fire_authorized         = 1'b0;
        bus.reload                  = 1'b0;
        step("reset", S_IDLE, 4'd4);
        step("reset2", S_IDLE, 4'd4);
        rst = 1'b0;

        engage("eng1", 4'd4);

        bus.fire_authorized    = 1'b0;
        bus.distance_to_target = 32'd999;
        step("d999a", S_IDLE, 4'd3);
        step("d999b", S_IDLE, 4'd3);
        bus.distance_to_target = 32'd1000;
        step("d1000", S_LOCK, 4'd3);
        step("lk2", S_LOCK, 4'd3);
        step("lk3", S_LOCK, 4'd3);
        bus.threat_detected = 1'b0;
        step("drop", S_IDLE, 4'd3);
        bus.threat_detected = 1'b1;
        step("re1", S_LOCK, 4'd3);
        step("re2", S_LOCK, 4'd3);
        step("re3", S_LOCK, 4'd3);
        step("re4", S_ARM, 4'd3);
        bus.reload = 1'b1;
        step("rld_arm", S_ARM, 4'd3);
        bus.reload = 1'b0;

        bus.fire_authorized         = 1'b1;
        bus.safe_to_engage          = 1'b1;
        bus.emergency_landing_alert = 1'b1;
        step("alert_arm", S_SAFE, 4'd3);
        step("safe_hold", S_SAFE, 4'd3);
        bus.reload = 1'b1;
        step("rld_safe", S_SAFE, 4'd4);
        bus.reload                  = 1'b0;
        bus.emergency_landing_alert = 1'b0;
        step("safe_exit", S_IDLE, 4'd4);

        engage("eng2", 4'd4);
        engage("eng3", 4'd3);
        engage("eng4", 4'd2);
        engage("eng5", 4'd1);
        step("empty1", S_IDLE, 4'd0);
        step("empty2", S_IDLE, 4'd0);
        bus.reload = 1'b1;
        step("rld_idle", S_IDLE, 4'd4);
        bus.reload = 1'b0;

        for (int i = 0; i < 3; i++) step("al_lock", S_LOCK, 4'd4);
        step("al_arm", S_ARM, 4'd4);
        step("al_launch", S_LNCH, 4'd4);
        bus.emergency_landing_alert = 1'b1;
        step("alert_lnch", S_SAFE, 4'd3);
        bus.emergency_landing_alert = 1'b0;
        step("al_exit", S_IDLE, 4'd3);

        for (int i = 0; i < 3; i++) step("rc_lock", S_LOCK, 4'd3);
        step("rc_arm", S_ARM, 4'd3);
        step("rc_launch", S_LNCH, 4'd3);
        for (int i = 0; i < 3; i++) step("rc_cool", S_COOL, 4'd2);
        rst = 1'b1;
        step("rst_cool", S_IDLE, 4'd4);
        rst = 1'b0;
        bus.threat_detected = 1'b0;
        step("post_rst", S_IDLE, 4'd4);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/weapons_engagement_unit.md
# weapons_engagement_unit

Downstream consumer of the integrated combat management outputs: it takes `threat_detected`, `distance_to_target`, `safe_to_engage` and `emergency_landing_alert` and decides when a missile is released. It runs a lock-on and arming sequence, keeps a missile inventory and enforces a post-launch cooldown. Emergency landing safes the unit from any state.

## Interface
Parameters:
- LOCK_CYCLES, 4: consecutive qualifying cycles required for lock (≥1).
- COOLDOWN_CYCLES, 8: cycles spent in COOLDOWN after a launch (≥1).
- MISSILE_COUNT, 4: inventory after reset or reload (1..15).
- MIN_ENGAGE_DIST, 1000: minimum `distance_to_target` for a lock to qualify (unsigned).

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RST  input  1  synchronous, active-high reset.
- threat_detected  input  1  target-present flag from ARTAU.
- distance_to_target  input  32  unsigned range from ARTAU.
- safe_to_engage  input  1  engagement permission.
- emergency_landing_alert  input  1  from ECSU; highest priority after RST.
- fire_authorized  input  1  pilot trigger, level-sampled.
- reload  input  1  refills inventory (honoured only in IDLE or SAFED).
- missile_launch  output  1  high for exactly one cycle per launch.
- lock_acquired  output  1  high while in ARMED.
- missiles_remaining  output  4  current inventory.
- WEU_state  output  3  IDLE=0, LOCKING=1, ARMED=2, LAUNCH=3, COOLDOWN=4, SAFED=5.

## Operation
- Qualify = `threat_detected && distance_to_target >= MIN_ENGAGE_DIST`. The comparison is a 32-bit unsigned compare.
- IDLE:
  - Qualify && missiles_remaining != 0 → LOCKING, with lock_cnt = 1.
  - reload=1 sets missiles_remaining = MISSILE_COUNT. The refill has no effect on the state transition in the same cycle.
- LOCKING:
  - !qualify → IDLE, and lock_cnt clears.
  - qualify && lock_cnt == LOCK_CYCLES-1 → ARMED.
  - Otherwise lock_cnt increments and the unit stays in LOCKING.
  - With LOCK_CYCLES=1, IDLE goes directly to ARMED on the first qualify.
- ARMED:
  - !threat_detected → IDLE.
  - fire_authorized && safe_to_engage → LAUNCH.
  - Otherwise hold. The range is not rechecked here.
- LAUNCH:
  - Lasts one cycle. missiles_remaining decrements on the exit edge.
  - Next state is COOLDOWN, with cd_cnt = 0.
- COOLDOWN:
  - cd_cnt increments each cycle.
  - When cd_cnt == COOLDOWN_CYCLES-1 → IDLE.
  - Inputs are ignored, except the alert.
- SAFED:
  - Holds while emergency_landing_alert=1, then → IDLE.
  - reload is honoured. lock_cnt and cd_cnt are held at 0.
- emergency_landing_alert=1 in any state:
  - The next state is SAFED, overriding every other transition.
  - If this happens in LAUNCH, the launch pulse of that cycle stands and the inventory still decrements.
- Inventory:
  - It never wraps; LAUNCH is unreachable with 0 missiles.
  - reload and decrement never coincide (they occur in disjoint states).

## Timing
- All outputs are Moore, decoded from registered state and counters.
- Reset values: WEU_state=IDLE, missile_launch=0, lock_acquired=0, missiles_remaining=MISSILE_COUNT, lock_cnt=0, cd_cnt=0.
- RST takes effect at the next rising edge and overrides everything, including the alert. RST asserted mid-LAUNCH or mid-COOLDOWN aborts with no further pulse.
- Latency from threat to lock:
  - qualify sampled at edge N → LOCKING from N.
  - lock_acquired rises after edge N+LOCK_CYCLES-1, provided qualify holds at every edge.
- Latency from trigger to launch: fire_authorized && safe_to_engage sampled in ARMED at edge M → missile_launch high in cycle M..M+1, inventory updated after edge M+1.
- Cooldown occupies exactly COOLDOWN_CYCLES cycles. The earliest re-entry to LOCKING is the edge after returning to IDLE.
- A held fire_authorized yields one launch per full IDLE→LOCKING→ARMED cycle, never back-to-back launches.

## Test plan
- Reset, then threat=1, distance=5000, held with defaults → lock_acquired=1 after 4 edges; fire_authorized=1, safe=1 → one missile_launch pulse, missiles_remaining 4→3, COOLDOWN for 8 cycles, then IDLE.
- Threat=1, distance=999 → stays IDLE, no lock. Distance=1000 → lock qualifies.
- Threat dropped in the 3rd LOCKING cycle → IDLE, lock_cnt=0. Re-asserted → needs a full 4 cycles again.
- Four full engagements → missiles_remaining=0, and a further threat keeps IDLE. reload=1 in IDLE → inventory becomes 4. reload in ARMED → ignored.
- Alert asserted in ARMED with fire_authorized=1 → SAFED next edge, no launch. Alert in LAUNCH → pulse completes, inventory decrements, then SAFED. Alert drops → IDLE.
- RST asserted in COOLDOWN cycle 3 → IDLE and missiles_remaining=4 next edge, no pulse.
